branch_resolve_queue: RTL

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// Holds the branch predictor's guesses for every fetch that is still in
// flight. Fetch pushes one {pc, pred_pc, pred_taken} record per fetch. ex0
// later resolves the oldest fetch. The queue compares the guess against the
// real outcome, reports the result to the predictor, and on a mispredict asks
// fetch to restart from the corrected pc.
//
// Ports
//   clk, rstn           clock (rising edge); asynchronous active-low reset
//   enq_valid/ready     fetch-side handshake for a new prediction record
//   enq_pc              fetch pc of the record
//   enq_pred_pc         predicted next pc for that fetch
//   enq_pred_taken      predicted direction for that fetch
//   res_valid           ex0 resolves the oldest outstanding fetch
//   res_is_branch       the resolved instruction is a branch
//   res_taken           the branch was actually taken
//   res_tpc             actual branch target
//   flush               external pipeline flush (exception / ertn)
//   fact_pc/tpc/taken   registered predictor-update record
//   predict_dir_fail    registered direction-misprediction flag
//   predict_add_fail    registered target-misprediction flag
//   redirect_valid/pc   one-cycle fetch redirect with the corrected next pc
//   count               number of occupied entries
//   mispred_cnt         wrapping total of mispredictions
//   underflow_err       sticky flag: a resolve arrived while the queue was empty
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_pred_pc,
  input  logic                       enq_pred_taken,
  input  logic                       res_valid,
  input  logic                       res_is_branch,
  input  logic                       res_taken,
  input  logic [31:0]                res_tpc,
  input  logic                       flush,
  output logic [31:0]                fact_pc,
  output logic [31:0]                fact_tpc,
  output logic                       fact_taken,
  output logic                       predict_dir_fail,
  output logic                       predict_add_fail,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                mispred_cnt,
  output logic                       underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic {
    RUN,
    RECOVER
  } state_t;

  state_t state;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [31:0] pc_mem      [DEPTH];
  logic [31:0] pred_pc_mem [DEPTH];
  logic        taken_mem   [DEPTH];

  logic        enq_fire;
  logic        res_fire;
  logic        res_empty;
  logic [31:0] head_pc;
  logic [31:0] head_pred_pc;
  logic        head_pred_taken;
  logic        actual_taken;
  logic [31:0] fall_through;
  logic [31:0] actual_next;
  logic        dir_fail;
  logic        add_fail;
  logic        mispredict;

  // Accept only while running and strictly below capacity. A pop on the same
  // edge does not free a slot early, so this depends only on registered state.
  assign enq_ready = (state == RUN) && (count < FULL_COUNT);
  assign enq_fire  = enq_valid && enq_ready;

  // A resolve counts only in RUN, with something to pop, and without a flush.
  // The flush wins over everything else on the same edge.
  assign res_fire  = (state == RUN) && res_valid && (count != '0) && !flush;
  assign res_empty = (state == RUN) && res_valid && (count == '0);

  assign head_pc         = pc_mem[head];
  assign head_pred_pc    = pred_pc_mem[head];
  assign head_pred_taken = taken_mem[head];

  // Fetch works on 8-byte aligned pairs. A pc in the upper half of a pair
  // falls through to the next pair (+4). A pc in the lower half skips over its
  // partner (+8).
  assign actual_taken = res_is_branch && res_taken;
  assign fall_through = head_pc[2] ? (head_pc + 32'd4) : (head_pc + 32'd8);
  assign actual_next  = actual_taken ? res_tpc : fall_through;

  // A target mismatch only matters when both sides agree the branch was taken.
  // A wrong direction is reported separately through dir_fail.
  assign dir_fail   = head_pred_taken != actual_taken;
  assign add_fail   = head_pred_taken && actual_taken && (head_pred_pc != res_tpc);
  assign mispredict = res_fire && (dir_fail || add_fail);

  // Record storage has no reset. Entries are only read after they were
  // written, because count guards every pop. A write that lands on a
  // mispredict or flush edge is harmless, since the pointers are cleared on
  // that same edge.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[tail]      <= enq_pc;
      pred_pc_mem[tail] <= enq_pred_pc;
      taken_mem[tail]   <= enq_pred_taken;
    end
  end

  // Control FSM plus pointers, occupancy and every registered output.
  // A mispredict or flush in RUN empties the queue and spends one RECOVER
  // cycle. During that cycle fetch cannot push and ex0 resolves are dropped.
  // The record outputs carry data only in the cycle after a real resolve, and
  // are zero in every other cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= RUN;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      fact_pc          <= '0;
      fact_tpc         <= '0;
      fact_taken       <= 1'b0;
      predict_dir_fail <= 1'b0;
      predict_add_fail <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      mispred_cnt      <= '0;
      underflow_err    <= 1'b0;
    end else begin
      fact_pc          <= res_fire ? head_pc : 32'd0;
      fact_tpc         <= res_fire ? res_tpc : 32'd0;
      fact_taken       <= res_fire && actual_taken;
      predict_dir_fail <= res_fire && dir_fail;
      predict_add_fail <= res_fire && add_fail;
      redirect_valid   <= mispredict;
      redirect_pc      <= mispredict ? actual_next : 32'd0;

      if (res_empty) begin
        underflow_err <= 1'b1;
      end

      if (mispredict) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end

      case (state)
        RUN: begin
          if (flush || mispredict) begin
            state <= RECOVER;
            head  <= '0;
            tail  <= '0;
            count <= '0;
          end else begin
            if (enq_fire) begin
              tail <= tail + PTR_W'(1);
            end
            if (res_fire) begin
              head <= head + PTR_W'(1);
            end
            case ({enq_fire, res_fire})
              2'b10:   count <= count + CNT_W'(1);
              2'b01:   count <= count - CNT_W'(1);
              default: count <= count;
            endcase
          end
        end
        RECOVER: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
